// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared definitions for the AXI4-Lite initiator: FSM state encoding, AXI
// response codes, AXI protection encodings and a response classifier.
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AxPROT[2] marks an instruction access; the core is always privileged-agnostic
  // and secure, so bits [1:0] stay zero.
  localparam logic [2:0] PROT_DATA = 3'b000;
  localparam logic [2:0] PROT_INSN = 3'b100;

  // Anything other than OKAY (including EXOKAY, which a non-exclusive access
  // should never receive) is reported to the core as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_initiator_if.sv
// -----------------------------------------------------------------------------
// axi4_lite_initiator_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master : initiator side (drives addresses, data, valids, readies)
//   slave  : responder side (drives readies, responses, read data)
// Parameters: ADDR_W address width, DATA_W data width (DATA_W/8 strobes).
// -----------------------------------------------------------------------------
interface axi4_lite_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

endinterface

// File: rtl/axi4_lite_timeout.sv
// -----------------------------------------------------------------------------
// axi4_lite_timeout
// Watchdog for the AXI4-Lite initiator. A 16-bit counter runs while the FSM
// waits on the bus and is held at zero otherwise, so it restarts every time a
// transaction leaves IDLE.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   busy_i       FSM is in a read/write wait state
//   expired_o    the count reaches TIMEOUT_CYCLES on the coming edge
// -----------------------------------------------------------------------------
module axi4_lite_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic busy_i,
  output logic expired_o
);

  // The counter shows k-1 during the k-th busy cycle, so flagging at
  // TIMEOUT_CYCLES-1 lands the abort on the edge where the count hits the limit.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = busy_i ? cnt_q + 16'd1 : 16'd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = busy_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/axi4_lite_initiator.sv
// -----------------------------------------------------------------------------
// axi4_lite_initiator
// Bridges the core's native memory bus (mem_valid/mem_ready) to an AXI4-Lite
// initiator port, one transaction outstanding at a time. A request with
// mem_wstrb == 0 becomes AR->R, otherwise AW+W->B. Completion is a one-cycle
// mem_ready pulse with mem_rdata (0 for writes) and mem_err (resp != OKAY).
//
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   mem_valid/_instr/_addr/_wdata/_wstrb   native request (sampled in IDLE only)
//   mem_ready/_rdata/_err                  native completion (registered)
//   mem_axi         AXI4-Lite bus, master modport
//
// Build option: define AXI_TIMEOUT_EN to add a watchdog that aborts a stalled
// transaction after TIMEOUT_CYCLES busy cycles with mem_err=1, mem_rdata=0.
// Without it the FSM waits on the responder indefinitely.
// -----------------------------------------------------------------------------
module axi4_lite_initiator
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_err,

  axi4_lite_initiator_if.master mem_axi
);

  state_e                state_q, state_d;

  logic                  arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]     araddr_q,  araddr_d;
  logic [2:0]            arprot_q,  arprot_d;
  logic                  rready_q,  rready_d;

  logic                  awvalid_q, awvalid_d;
  logic [ADDR_W-1:0]     awaddr_q,  awaddr_d;
  logic [2:0]            awprot_q,  awprot_d;
  logic                  wvalid_q,  wvalid_d;
  logic [DATA_W-1:0]     wdata_q,   wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q,   wstrb_d;
  logic                  bready_q,  bready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q,  w_done_d;

  logic                  mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;
  logic                  mem_err_q,   mem_err_d;

  logic                  ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic                  timeout_hit;

  // Handshakes are judged on our registered valid/ready, so a channel can
  // complete at most once per transaction.
  assign ar_hs = arvalid_q & mem_axi.arready;
  assign r_hs  = rready_q  & mem_axi.rvalid;
  assign aw_hs = awvalid_q & mem_axi.awready;
  assign w_hs  = wvalid_q  & mem_axi.wready;
  assign b_hs  = bready_q  & mem_axi.bvalid;

`ifdef AXI_TIMEOUT_EN
  logic busy;
  assign busy = (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA) ||
                (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP);

  axi4_lite_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .resetn    (resetn),
    .busy_i    (busy),
    .expired_o (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state value is defaulted to hold before the case, so no
    // path through the decode can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arprot_d    = arprot_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    awaddr_d    = awaddr_q;
    awprot_d    = awprot_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_err_d   = mem_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          if (mem_wstrb == '0) begin
            araddr_d  = mem_addr;
            arprot_d  = mem_instr ? PROT_INSN : PROT_DATA;
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end else begin
            awaddr_d  = mem_addr;
            awprot_d  = PROT_DATA;
            wdata_d   = mem_wdata;
            wstrb_d   = mem_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WR_REQ;
          end
        end
      end

      ST_RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (r_hs) begin
          mem_rdata_d = mem_axi.rdata;
          mem_err_d   = resp_is_err(mem_axi.rresp);
          rready_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_WR_REQ: begin
        // AW and W retire independently; the last one to finish (or both in
        // the same cycle) opens the B channel.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (b_hs) begin
          mem_rdata_d = '0;
          mem_err_d   = resp_is_err(mem_axi.bresp);
          bready_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        // mem_ready is high for this single cycle; IDLE takes the next request.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog abort wins over any handshake in the same cycle; a response
    // arriving afterwards finds every ready low and IDLE ignores it.
    if (timeout_hit) begin
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      mem_rdata_d = '0;
      mem_err_d   = 1'b1;
      mem_ready_d = 1'b1;
      state_d     = ST_DONE;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the datapath is reset too because outputs must read 0
  // during reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arprot_q    <= '0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      awprot_q    <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arprot_q    <= arprot_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      awprot_q    <= awprot_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_ready       = mem_ready_q;
  assign mem_rdata       = mem_rdata_q;
  assign mem_err         = mem_err_q;

  assign mem_axi.arvalid = arvalid_q;
  assign mem_axi.araddr  = araddr_q;
  assign mem_axi.arprot  = arprot_q;
  assign mem_axi.rready  = rready_q;
  assign mem_axi.awvalid = awvalid_q;
  assign mem_axi.awaddr  = awaddr_q;
  assign mem_axi.awprot  = awprot_q;
  assign mem_axi.wvalid  = wvalid_q;
  assign mem_axi.wdata   = wdata_q;
  assign mem_axi.wstrb   = wstrb_q;
  assign mem_axi.bready  = bready_q;

endmodule

// File: tb/tb_axi4_lite_initiator.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_initiator
// Directed and randomized requests against axi4_lite_initiator. The bench plays
// both the core and an AXI4-Lite responder with programmable per-channel delays
// and response codes. Expected read data, error flags and protection bits come
// from a word-addressed memory model updated with byte-strobe arithmetic.
// With AXI_TIMEOUT_EN defined the watchdog abort is exercised (TIMEOUT_CYCLES=8);
// otherwise a long responder stall must complete normally.
// -----------------------------------------------------------------------------
module tb_axi4_lite_initiator;

  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  axi4_lite_initiator_if #(.ADDR_W(32), .DATA_W(32)) mem_axi ();

  axi4_lite_initiator #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .mem_axi   (mem_axi)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Responder storage and the independent reference model.
  logic [31:0] resp_mem [logic [29:0]];
  logic [31:0] ref_mem  [logic [29:0]];

  function automatic logic [31:0] resp_read(input logic [31:0] a);
    if (resp_mem.exists(a[31:2])) return resp_mem[a[31:2]];
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One core request plus matching responder activity.
  // d_a: AR/AW ready delay after valid seen, d_w: W ready delay,
  // d_r: R/B valid delay after the address (read) or both write handshakes.
  task automatic do_request(input string tag, input bit wr, input bit instr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int d_a, input int d_w,
                            input int d_r, input logic [1:0] resp, input int exp_lat,
                            output logic [31:0] rdata_o);
    logic [31:0] word, exp_rdata, obs_rdata;
    logic        exp_err, obs_err, got, aw_ok, w_ok, early;
    logic [2:0]  exp_prot;
    int          lat;

    word = ref_read(addr);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) word[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[addr[31:2]] = word;
      exp_rdata = 32'h0;
    end else begin
      exp_rdata = word;
    end
    exp_err  = (resp != 2'b00);
    exp_prot = (!wr && instr) ? 3'b100 : 3'b000;

    got = 1'b0; aw_ok = 1'b0; w_ok = 1'b0; early = 1'b0; lat = -1;
    obs_rdata = 'x; obs_err = 1'bx;

    @(negedge clk);
    mem_valid = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wr ? strb : 4'b0000;

    fork
      begin
        for (int c = 1; c <= BUDGET; c++) begin
          @(negedge clk);
          if (c == 1) begin
            // Inputs after the sampling edge must not matter.
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_wstrb = 4'($urandom);
            mem_instr = ~mem_instr;
          end
          if (mem_ready === 1'b1) begin
            got = 1'b1; lat = c - 1;
            obs_rdata = mem_rdata; obs_err = mem_err;
            mem_valid = 1'b0;
            break;
          end
        end
      end
      begin
        if (!wr) begin
          for (int c = 0; c < BUDGET && mem_axi.arvalid !== 1'b1; c++) @(negedge clk);
          check({tag, " arvalid"}, mem_axi.arvalid, 1'b1);
          check({tag, " araddr"}, mem_axi.araddr, addr);
          check({tag, " arprot"}, mem_axi.arprot, exp_prot);
          repeat (d_a) @(negedge clk);
          mem_axi.arready = 1'b1;
          @(negedge clk);
          mem_axi.arready = 1'b0;
          check({tag, " arvalid drop"}, mem_axi.arvalid, 1'b0);
          check({tag, " rready"}, mem_axi.rready, 1'b1);
          repeat (d_r) @(negedge clk);
          mem_axi.rvalid = 1'b1;
          mem_axi.rdata  = resp_read(addr);
          mem_axi.rresp  = resp;
          @(negedge clk);
          mem_axi.rvalid = 1'b0;
          mem_axi.rdata  = $urandom;
        end else begin
          fork
            begin
              for (int c = 0; c < BUDGET && mem_axi.awvalid !== 1'b1; c++) @(negedge clk);
              check({tag, " awaddr"}, mem_axi.awaddr, addr);
              check({tag, " awprot"}, mem_axi.awprot, 3'b000);
              repeat (d_a) @(negedge clk);
              mem_axi.awready = 1'b1;
              @(negedge clk);
              mem_axi.awready = 1'b0;
              check({tag, " awvalid drop"}, mem_axi.awvalid, 1'b0);
              aw_ok = 1'b1;
            end
            begin
              for (int c = 0; c < BUDGET && mem_axi.wvalid !== 1'b1; c++) @(negedge clk);
              check({tag, " wdata"}, mem_axi.wdata, wdata);
              check({tag, " wstrb"}, mem_axi.wstrb, strb);
              repeat (d_w) @(negedge clk);
              mem_axi.wready = 1'b1;
              @(negedge clk);
              mem_axi.wready = 1'b0;
              word = resp_read(addr);
              for (int b = 0; b < 4; b++)
                if (strb[b]) word[8*b +: 8] = wdata[8*b +: 8];
              resp_mem[addr[31:2]] = word;
              check({tag, " wvalid drop"}, mem_axi.wvalid, 1'b0);
              w_ok = 1'b1;
            end
            begin
              for (int c = 0; c < BUDGET; c++) begin
                @(negedge clk);
                #1;
                if (aw_ok && w_ok) break;
                if (mem_axi.bready === 1'b1) early = 1'b1;
              end
              check({tag, " bready early"}, early, 1'b0);
              check({tag, " bready"}, mem_axi.bready, 1'b1);
              repeat (d_r) @(negedge clk);
              mem_axi.bvalid = 1'b1;
              mem_axi.bresp  = resp;
              @(negedge clk);
              mem_axi.bvalid = 1'b0;
            end
          join
        end
      end
    join

    check({tag, " done"}, got, 1'b1);
    check({tag, " rdata"}, obs_rdata, exp_rdata);
    check({tag, " err"}, obs_err, exp_err);
    if (exp_lat >= 0) check({tag, " latency"}, lat, exp_lat);
    @(negedge clk);
    check({tag, " single pulse"}, mem_ready, 1'b0);
    rdata_o = obs_rdata;
  endtask

  initial begin : main
    logic [31:0] rd;
    logic        seen;

    mem_axi.awready = 1'b0;
    mem_axi.wready  = 1'b0;
    mem_axi.bvalid  = 1'b0;
    mem_axi.bresp   = 2'b00;
    mem_axi.arready = 1'b0;
    mem_axi.rvalid  = 1'b0;
    mem_axi.rdata   = '0;
    mem_axi.rresp   = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ctrl", {mem_axi.arvalid, mem_axi.rready, mem_axi.awvalid, mem_axi.wvalid,
                         mem_axi.bready, mem_ready, mem_err}, 7'b0);
    check("reset data", {mem_axi.araddr, mem_axi.awaddr}, 64'h0);
    check("reset rdata", {mem_rdata, mem_axi.wdata}, 64'h0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: plain read, zero-wait responder latency
    resp_mem[30'h10] = 32'h1234_5678;
    ref_mem[30'h10]  = 32'h1234_5678;
    do_request("t1 read", 1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1, 0, 0, 2'b00, 3, rd);
    check("t1 value", rd, 32'h1234_5678);

    // 2: instruction fetch
    do_request("t2 fetch", 1'b0, 1'b1, 32'h44, 32'h0, 4'h0, 2, 0, 1, 2'b00, -1, rd);

    // zero-wait write latency
    do_request("zw write", 1'b1, 1'b0, 32'h20, 32'h0BAD_F00D, 4'hF, 1, 1, 0, 2'b00, 3, rd);

    // 3: split write handshakes in both orders and together
    do_request("t3 aw first", 1'b1, 1'b0, 32'h10, 32'hA5A5_0F0F, 4'b0011, 0, 3, 0, 2'b00, -1, rd);
    do_request("t3 readback", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 2'b00, -1, rd);
    check("t3 low bytes", rd[15:0], 16'h0F0F);
    do_request("w first", 1'b1, 1'b0, 32'h14, 32'h1122_3344, 4'b1100, 3, 0, 2, 2'b00, -1, rd);
    do_request("aw w same", 1'b1, 1'b0, 32'h14, 32'h5566_7788, 4'b0001, 2, 2, 0, 2'b00, -1, rd);
    do_request("w readback", 1'b0, 1'b0, 32'h14, 32'h0, 4'h0, 1, 0, 0, 2'b00, -1, rd);

    // 4: error responses
    do_request("t4 bresp slverr", 1'b1, 1'b0, 32'h30, 32'hCAFE_BABE, 4'hF, 1, 1, 1, 2'b10, -1, rd);
    do_request("t4 read okay", 1'b0, 1'b0, 32'h30, 32'h0, 4'h0, 1, 0, 0, 2'b00, -1, rd);
    do_request("rresp decerr", 1'b0, 1'b0, 32'h34, 32'h0, 4'h0, 0, 0, 2, 2'b11, -1, rd);
    do_request("rresp exokay", 1'b0, 1'b0, 32'h38, 32'h0, 4'h0, 0, 0, 0, 2'b01, -1, rd);

    // 5: reset while in RD_DATA
    @(negedge clk);
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h80; mem_wstrb = 4'h0;
    for (int c = 0; c < BUDGET && mem_axi.arvalid !== 1'b1; c++) @(negedge clk);
    mem_axi.arready = 1'b1;
    @(negedge clk);
    mem_axi.arready = 1'b0;
    check("t5 in rd_data", mem_axi.rready, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("t5 async ctrl", {mem_axi.arvalid, mem_axi.rready, mem_axi.awvalid, mem_axi.wvalid,
                            mem_axi.bready, mem_ready, mem_err}, 7'b0);
    check("t5 async addr", mem_axi.araddr, 32'h0);
    mem_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_ready !== 1'b0) seen = 1'b1;
    end
    resetn = 1'b1;
    @(negedge clk);
    if (mem_ready !== 1'b0) seen = 1'b1;
    check("t5 no pulse", seen, 1'b0);
    do_request("t5 after reset", 1'b0, 1'b0, 32'h80, 32'h0, 4'h0, 1, 1, 0, 2'b00, -1, rd);

`ifdef AXI_TIMEOUT_EN
    // 6: responder never accepts AR
    begin
      int          lat;
      logic        er, arv;
      lat = -1; er = 1'bx; arv = 1'bx; rd = 'x;
      @(negedge clk);
      mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h200; mem_wstrb = 4'h0;
      for (int c = 1; c <= BUDGET; c++) begin
        @(negedge clk);
        if (mem_ready === 1'b1) begin
          lat = c - 1; rd = mem_rdata; er = mem_err; arv = mem_axi.arvalid;
          mem_valid = 1'b0;
          break;
        end
      end
      check("t6 timeout latency", lat, 8);
      check("t6 err", er, 1'b1);
      check("t6 rdata", rd, 32'h0);
      check("t6 arvalid drop", arv, 1'b0);
      @(negedge clk);
      check("t6 single pulse", mem_ready, 1'b0);
      do_request("t6 recover", 1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 1, 0, 1, 2'b00, -1, rd);
    end
`else
    // Long stall must simply be waited out.
    do_request("stall read", 1'b0, 1'b0, 32'h60, 32'h0, 4'h0, 40, 0, 30, 2'b00, -1, rd);
    do_request("stall write", 1'b1, 1'b0, 32'h64, 32'h89AB_CDEF, 4'b1010, 25, 35, 20, 2'b00, -1, rd);
`endif

    // Randomized traffic over a small address window
    for (int i = 0; i < 24; i++) begin
      bit          wr, instr;
      logic [31:0] addr;
      logic [3:0]  strb;
      wr    = 1'($urandom_range(0, 1));
      instr = 1'($urandom_range(0, 1));
      addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      strb  = 4'($urandom_range(1, 15));
      do_request($sformatf("rand%0d", i), wr, instr, addr, $urandom, strb,
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                 2'($urandom_range(0, 3)), -1, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
